// File: rtl/lifo_reorder_pkg.sv
// Bank state encodings shared by the NTT reorder blocks.
package lifo_reorder_pkg;

  typedef logic [1:0] bank_state_t;

  localparam bank_state_t BANK_EMPTY   = 2'd0;
  localparam bank_state_t BANK_FULL    = 2'd1;
  localparam bank_state_t BANK_READING = 2'd2;

endpackage

// File: rtl/lifo_reorder_bank_ram.sv
// Simple dual-port RAM holding both ping-pong banks; the read register is the block output.
module lifo_reorder_bank_ram #(
  parameter int DEPTH = 8,
  parameter int DATA  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [$clog2(2*DEPTH)-1:0]    waddr,
  input  logic [DATA-1:0]               wdata,
  input  logic                          re,
  input  logic [$clog2(2*DEPTH)-1:0]    raddr,
  output logic [DATA-1:0]               rdata
);

  logic [DATA-1:0] mem [2*DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/lifo_reorder.sv
// Ping-pong block-reversal buffer: fills one bank in order while the other is read back in reverse.
module lifo_reorder
  import lifo_reorder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DATA  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DATA-1:0] data_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DATA-1:0] data_out,
  output logic            out_last
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // valid never waits on ready, and out_valid/data_out/out_last hold while out_ready is low.

  localparam int CW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH - 1);

  bank_state_t   state [2];
  logic          wr_bank;
  logic          rd_bank;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;
  logic          wr_en;
  logic          load;
  logic          rd_avail;
  logic          rd_en;

  assign in_ready = (state[wr_bank] == BANK_EMPTY);
  assign wr_en    = in_valid && in_ready;
  assign load     = !out_valid || out_ready;
  assign rd_avail = (state[rd_bank] != BANK_EMPTY);
  assign rd_en    = load && rd_avail;

  // Write and read never touch the same bank in one cycle: one needs EMPTY, the other not.
  always_ff @(posedge clk) begin
    if (rst) begin
      state[0]  <= BANK_EMPTY;
      state[1]  <= BANK_EMPTY;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= CNT_MAX;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_cnt == CNT_MAX) begin
          state[wr_bank] <= BANK_FULL;
          wr_bank        <= ~wr_bank;
        end
      end
      if (load) out_valid <= rd_avail;
      if (rd_en) begin
        out_last <= (rd_cnt == '0);
        rd_cnt   <= rd_cnt - 1'b1;
        if (rd_cnt == '0) begin
          state[rd_bank] <= BANK_EMPTY;
          rd_bank        <= ~rd_bank;
        end else begin
          state[rd_bank] <= BANK_READING;
        end
      end
    end
  end

  lifo_reorder_bank_ram #(
    .DEPTH (DEPTH),
    .DATA  (DATA)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr ({wr_bank, wr_cnt}),
    .wdata (data_in),
    .re    (rd_en),
    .raddr ({rd_bank, rd_cnt}),
    .rdata (data_out)
  );

endmodule
